// File: rtl/uart_cmd_ctrl.sv
// Frames the UART byte stream (HEADER, cmd, arg, cmd^arg) into player commands
// and reports checksum, inter-byte timeout and overrun errors.
module uart_cmd_ctrl #(
    parameter int                   DATA_BITS   = 8,
    parameter logic [DATA_BITS-1:0] HEADER      = 8'hAA,
    parameter int                   TIMEOUT_CYC = 104170
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_done,
    input  logic [DATA_BITS-1:0] i_rx_data,
    output logic                 o_cmd_valid,
    input  logic                 i_cmd_ready,
    output logic [DATA_BITS-1:0] o_cmd,
    output logic [DATA_BITS-1:0] o_arg,
    output logic                 o_busy,
    output logic                 o_err_chk,
    output logic                 o_err_tmo,
    output logic                 o_err_ovr,
    output logic [7:0]           o_err_cnt
);

    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ARG,
        CHK,
        ISSUE
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_tmo_cnt;
    logic [DATA_BITS-1:0] r_cmd_lat;
    logic [DATA_BITS-1:0] r_arg_lat;
    logic                 r_cmd_valid;
    logic [DATA_BITS-1:0] r_cmd;
    logic [DATA_BITS-1:0] r_arg;
    logic                 r_busy;
    logic                 r_err_chk;
    logic                 r_err_tmo;
    logic                 r_err_ovr;
    logic [7:0]           r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tmo_cnt   <= '0;
            r_cmd_lat   <= '0;
            r_arg_lat   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
            r_arg       <= '0;
            r_busy      <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_err_ovr   <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_err_chk <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_ovr <= 1'b0;
            // Count follows the registered pulses, so it lags them by one cycle.
            if ((r_err_chk || r_err_tmo || r_err_ovr) && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;

            case (r_state)
                IDLE: begin
                    if (i_rx_done && i_rx_data == HEADER) begin
                        r_state   <= CMD;
                        r_busy    <= 1'b1;
                        r_tmo_cnt <= '0;
                    end
                end

                CMD, ARG, CHK: begin
                    if (i_rx_done) begin
                        r_tmo_cnt <= '0;
                        case (r_state)
                            CMD: begin
                                r_cmd_lat <= i_rx_data;
                                r_state   <= ARG;
                            end
                            ARG: begin
                                r_arg_lat <= i_rx_data;
                                r_state   <= CHK;
                            end
                            default: begin
                                if (i_rx_data == (r_cmd_lat ^ r_arg_lat)) begin
                                    r_cmd       <= r_cmd_lat;
                                    r_arg       <= r_arg_lat;
                                    r_cmd_valid <= 1'b1;
                                    r_state     <= ISSUE;
                                end else begin
                                    r_err_chk <= 1'b1;
                                    r_state   <= IDLE;
                                    r_busy    <= 1'b0;
                                end
                            end
                        endcase
                    end else if (r_tmo_cnt == TMO_MAX) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                ISSUE: begin
                    // No buffering: anything arriving while a command waits is lost.
                    if (i_rx_done)
                        r_err_ovr <= 1'b1;
                    if (r_cmd_valid && i_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd       = r_cmd;
    assign o_arg       = r_arg;
    assign o_busy      = r_busy;
    assign o_err_chk   = r_err_chk;
    assign o_err_tmo   = r_err_tmo;
    assign o_err_ovr   = r_err_ovr;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus queues expected commands/errors,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_cmd_ctrl;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic       o_cmd_valid;
    logic       i_cmd_ready;
    logic [7:0] o_cmd;
    logic [7:0] o_arg;
    logic       o_busy;
    logic       o_err_chk;
    logic       o_err_tmo;
    logic       o_err_ovr;
    logic [7:0] o_err_cnt;

    uart_cmd_ctrl #(.DATA_BITS(8), .HEADER(8'hAA), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd(o_cmd), .o_arg(o_arg),
        .o_busy(o_busy), .o_err_chk(o_err_chk), .o_err_tmo(o_err_tmo), .o_err_ovr(o_err_ovr),
        .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] cmd; logic [7:0] arg; int cyc; } cmd_t;
    typedef struct { logic [2:0] kind; int cyc; } err_t;  // kind = {chk,tmo,ovr}

    cmd_t cmd_q[$];
    err_t err_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;
    int   last_edge = 0;
    int   err_total = 0;
    int   hs_count = 0;
    bit   seen_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: commands and error pulses are compared against the queues.
    always @(negedge clk) begin
        if (o_cmd_valid === 1'b1) begin
            if (cmd_q.size() == 0) begin
                check("unexpected_valid", 32'(o_cmd_valid), 32'd0);
            end else begin
                check("cmd", 32'(o_cmd), 32'(cmd_q[0].cmd));
                check("arg", 32'(o_arg), 32'(cmd_q[0].arg));
                if (!seen_valid) begin
                    check("valid_lat", 32'(cyc), 32'(cmd_q[0].cyc));
                    seen_valid = 1;
                end
                if (i_cmd_ready) begin
                    void'(cmd_q.pop_front());
                    seen_valid = 0;
                    hs_count++;
                end
            end
        end
        if ((o_err_chk | o_err_tmo | o_err_ovr) === 1'b1) begin
            if (err_q.size() == 0) begin
                check("unexpected_err", 32'({o_err_chk, o_err_tmo, o_err_ovr}), 32'd0);
            end else begin
                check("err_kind", 32'({o_err_chk, o_err_tmo, o_err_ovr}), 32'(err_q[0].kind));
                check("err_cyc", 32'(cyc), 32'(err_q[0].cyc));
                void'(err_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        last_edge = cyc + 1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
        send_byte(h);
        send_byte(c);
        send_byte(a);
        send_byte(s);
    endtask

    task automatic exp_cmd(input logic [7:0] c, input logic [7:0] a);
        cmd_t e;
        e.cmd = c; e.arg = a; e.cyc = last_edge;
        cmd_q.push_back(e);
    endtask

    task automatic exp_err(input logic [2:0] k, input int at);
        err_t e;
        e.kind = k; e.cyc = at;
        err_q.push_back(e);
        err_total++;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((cmd_q.size() != 0 || err_q.size() != 0 || o_busy) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check({name, "_timeout"}, 32'(cmd_q.size() + err_q.size()), 32'd0);
        repeat (3) tick();
        check({name, "_busy"}, 32'(o_busy), 32'd0);
        check({name, "_errcnt"}, 32'(o_err_cnt), 32'(err_total > 255 ? 255 : err_total));
    endtask

    initial begin
        rst_n = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00; i_cmd_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(o_cmd_valid), 32'd0);
        check("rst_outs", 32'({o_cmd, o_arg, o_err_cnt}), 32'd0);
        check("rst_flags", 32'({o_busy, o_err_chk, o_err_tmo, o_err_ovr}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Valid frame with ready high, then a back-to-back frame one cycle after IDLE.
        send_frame(8'hAA, 8'h01, 8'h05, 8'h04); exp_cmd(8'h01, 8'h05);
        tick();
        send_frame(8'hAA, 8'h02, 8'h02, 8'h00); exp_cmd(8'h02, 8'h02);
        wait_idle("valid");
        check("hs_two", 32'(hs_count), 32'd2);

        // Checksum mismatch.
        send_frame(8'hAA, 8'h02, 8'h03, 8'h00); exp_err(3'b100, last_edge);
        wait_idle("chk");

        // Timeout after the cmd byte, then a normal frame.
        send_byte(8'hAA);
        send_byte(8'h07); exp_err(3'b010, last_edge + T);
        repeat (T + 5) tick();
        check("tmo_busy", 32'(o_busy), 32'd0);
        send_frame(8'hAA, 8'h03, 8'h04, 8'h07); exp_cmd(8'h03, 8'h04);
        wait_idle("tmo");

        // Overrun: command held with ready low; third byte lands on the handshake cycle.
        i_cmd_ready = 1'b0;
        send_frame(8'hAA, 8'h10, 8'h20, 8'h30); exp_cmd(8'h10, 8'h20);
        tick();
        send_byte(8'h11); exp_err(3'b001, last_edge);
        tick();
        send_byte(8'h22); exp_err(3'b001, last_edge);
        repeat (4) tick();
        check("ovr_hold_valid", 32'(o_cmd_valid), 32'd1);
        i_cmd_ready = 1'b1;
        send_byte(8'h33); exp_err(3'b001, last_edge);
        wait_idle("ovr");
        check("hs_ovr", 32'(hs_count), 32'd4);

        // Noise in IDLE is ignored.
        send_byte(8'h55); send_byte(8'h00); send_byte(8'hFF);
        send_frame(8'hAA, 8'h01, 8'h01, 8'h00); exp_cmd(8'h01, 8'h01);
        wait_idle("noise");

        // Reset mid-frame (in ARG) discards it and clears the error count.
        send_byte(8'hAA); send_byte(8'h04);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        err_total = 0;
        check("rst2_outs", 32'({o_cmd_valid, o_cmd, o_arg, o_err_cnt}), 32'd0);
        check("rst2_busy", 32'(o_busy), 32'd0);
        send_frame(8'hAA, 8'h04, 8'h08, 8'h0C); exp_cmd(8'h04, 8'h08);
        wait_idle("rst2");

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            send_frame(8'hAA, 8'h00, 8'h00, 8'h01); exp_err(3'b100, last_edge);
        end
        wait_idle("sat");
        check("sat_ff", 32'(o_err_cnt), 32'hFF);

        check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        check("err_q_empty", 32'(err_q.size()), 32'd0);
        check("hs_total", 32'(hs_count), 32'd6);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
